// File: rtl/count_sequencer.sv
// Prescaled up-counter sequencer with start/stop/pause control, one-shot or
// auto-reload against a latched limit, and a single-cycle done pulse.
module count_sequencer #(
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic [WIDTH-1:0]      cfg_limit,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  logic                  cfg_reload,
    output logic [WIDTH-1:0]      q,
    output logic                  busy,
    output logic                  paused,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_r, state_s;
    logic [WIDTH-1:0]      q_r, q_s;
    logic [PRESCALE_W-1:0] pc_r, pc_s;
    logic [WIDTH-1:0]      lim_r, lim_s;
    logic [PRESCALE_W-1:0] pre_r, pre_s;
    logic                  rl_r, rl_s;
    logic                  done_r, done_s;
    logic [WIDTH-1:0]      next_count_s;

    // Counting past the limit wraps to zero, so q never exceeds the limit
    assign next_count_s = (q_r == lim_r) ? {WIDTH{1'b0}}
                                         : q_r + {{(WIDTH-1){1'b0}}, 1'b1};

    // Next-state and next-register computation, commands in priority order
    always_comb begin
        state_s = state_r;
        q_s     = q_r;
        pc_s    = pc_r;
        lim_s   = lim_r;
        pre_s   = pre_r;
        rl_s    = rl_r;
        done_s  = 1'b0;
        if (stop) begin
            state_s = ST_IDLE;
            q_s     = {WIDTH{1'b0}};
            pc_s    = {PRESCALE_W{1'b0}};
        end else if (start) begin
            lim_s   = cfg_limit;
            pre_s   = cfg_prescale;
            rl_s    = cfg_reload;
            state_s = ST_RUN;
            q_s     = {WIDTH{1'b0}};
            pc_s    = {PRESCALE_W{1'b0}};
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (pause) begin
                        state_s = ST_PAUSE;
                    end else if (pc_r == pre_r) begin
                        pc_s = {PRESCALE_W{1'b0}};
                        q_s  = next_count_s;
                        if (next_count_s == lim_r) begin
                            done_s  = 1'b1;
                            state_s = rl_r ? ST_RUN : ST_DONE;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        pc_s = pc_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_PAUSE: begin
                    if (!pause) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_PAUSE;
                    end
                end
                ST_IDLE: state_s = ST_IDLE;
                ST_DONE: state_s = ST_DONE;
                default: begin
                    state_s = ST_IDLE;
                    q_s     = {WIDTH{1'b0}};
                    pc_s    = {PRESCALE_W{1'b0}};
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            q_r     <= {WIDTH{1'b0}};
            pc_r    <= {PRESCALE_W{1'b0}};
            lim_r   <= {WIDTH{1'b0}};
            pre_r   <= {PRESCALE_W{1'b0}};
            rl_r    <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            q_r     <= q_s;
            pc_r    <= pc_s;
            lim_r   <= lim_s;
            pre_r   <= pre_s;
            rl_r    <= rl_s;
            done_r  <= done_s;
        end
    end

    assign q      = q_r;
    assign done   = done_r;
    assign busy   = (state_r == ST_RUN) || (state_r == ST_PAUSE);
    assign paused = (state_r == ST_PAUSE);

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: a modulo-arithmetic reference model
// predicts each cycle's outputs; a monitor compares them after every edge.
module tb_count_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, stop, pause, cfg_reload;
    logic [31:0] cfg_limit;
    logic [7:0]  cfg_prescale;
    logic [31:0] q;
    logic        busy, paused, done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] q;
        logic        busy;
        logic        paused;
        logic        done;
    } exp_t;
    exp_t exp_q[$];

    // reference model state
    bit          m_on, m_hold;
    logic [31:0] m_q, m_lim;
    int          m_phase, m_pre;
    bit          m_rl, m_done;

    always #5 clk = ~clk;

    count_sequencer #(.WIDTH(32), .PRESCALE_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .cfg_limit(cfg_limit), .cfg_prescale(cfg_prescale), .cfg_reload(cfg_reload),
        .q(q), .busy(busy), .paused(paused), .done(done)
    );

    // One clock of stimulus: drive inputs, advance the model, queue the prediction
    task automatic cycle(input bit rs, input bit st, input bit sp, input bit pa,
                         input logic [31:0] lim, input logic [7:0] pre, input bit rl);
        exp_t e;
        longint unsigned nq;
        @(negedge clk);
        reset = rs; start = st; stop = sp; pause = pa;
        cfg_limit = lim; cfg_prescale = pre; cfg_reload = rl;
        m_done = 1'b0;
        if (rs) begin
            m_on = 0; m_hold = 0; m_q = 0; m_phase = 0;
            m_lim = 0; m_pre = 0; m_rl = 0;
        end else if (sp) begin
            m_on = 0; m_hold = 0; m_q = 0; m_phase = 0;
        end else if (st) begin
            m_lim = lim; m_pre = int'(pre); m_rl = rl;
            m_on = 1; m_hold = 0; m_q = 0; m_phase = 0;
        end else if (m_on && !m_hold) begin
            if (pa) begin
                m_hold = 1;
            end else if (m_phase == m_pre) begin
                m_phase = 0;
                nq  = (longint'(m_q) + 1) % (longint'(m_lim) + 1);
                m_q = nq[31:0];
                if (m_q == m_lim) begin
                    m_done = 1'b1;
                    if (!m_rl) m_on = 0;
                end
            end else begin
                m_phase++;
            end
        end else if (m_on && m_hold && !pa) begin
            m_hold = 0;
        end
        e.q = m_q; e.busy = m_on; e.paused = m_on && m_hold; e.done = m_done;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b0, 1'b0, 1'b0, $urandom, 8'($urandom), 1'($urandom));
    endtask

    task automatic go(input logic [31:0] lim, input logic [7:0] pre, input bit rl);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, lim, pre, rl);
    endtask

    // run until the model count reaches the target or the budget runs out
    task automatic run_to(input logic [31:0] target, input int budget);
        int n = 0;
        while (m_q != target && n < budget) begin
            idle(1);
            n++;
        end
        total++;
        if (m_q != target) begin
            bad++;
            $display("FAIL run_to: count %0d, required %0d within %0d cycles", m_q, target, budget);
        end
    endtask

    // Monitor: compare the DUT against the oldest prediction after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total += 4;
                if (q !== e.q) begin
                    bad++;
                    $display("FAIL q: got %0d, required %0d at %0t", q, e.q, $time);
                end
                if (busy !== e.busy) begin
                    bad++;
                    $display("FAIL busy: got %b, required %b at %0t", busy, e.busy, $time);
                end
                if (paused !== e.paused) begin
                    bad++;
                    $display("FAIL paused: got %b, required %b at %0t", paused, e.paused, $time);
                end
                if (done !== e.done) begin
                    bad++;
                    $display("FAIL done: got %b, required %b at %0t", done, e.done, $time);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        cfg_limit = 32'd0; cfg_prescale = 8'd0; cfg_reload = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0);
        idle(3);
        // one-shot to 3, no prescale
        go(32'd3, 8'd0, 1'b0);
        idle(6);
        // auto-reload to 2 with prescale 2
        go(32'd2, 8'd2, 1'b1);
        idle(18);
        // pause for 4 cycles at q=4
        go(32'd10, 8'd0, 1'b0);
        run_to(32'd4, 20);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd99, 8'd9, 1'b1);
        idle(10);
        // stop and start together at q=5
        go(32'd10, 8'd0, 1'b0);
        run_to(32'd5, 20);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd4, 8'd0, 1'b0);
        idle(3);
        // restart mid-run with a new limit
        go(32'd20, 8'd0, 1'b1);
        run_to(32'd7, 20);
        go(32'd2, 8'd0, 1'b0);
        idle(5);
        // zero limit, one-shot then auto-reload
        go(32'd0, 8'd0, 1'b0);
        idle(3);
        go(32'd0, 8'd1, 1'b1);
        idle(6);
        // pause outside RUN is ignored
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd3, 8'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd3, 8'd0, 1'b0);
        // random traffic with small limits and prescales
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(299) == 0), ($urandom_range(39) == 0),
                  ($urandom_range(79) == 0), ($urandom_range(5) == 0),
                  32'($urandom_range(6)), 8'($urandom_range(3)), 1'($urandom));
        end
        idle(2);
        repeat (3) @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
Controller that sequences a WIDTH-bit incrementing counter for timed events. It accepts start, stop and pause commands and scales the count rate with a programmable prescaler. It runs one-shot or auto-reload against a programmable limit and flags completion with a single-cycle done pulse. It sits between software-visible control registers and any logic consuming a free-running or terminal-count value.

Parameters:
WIDTH, 32, width of count output q and of cfg_limit
PRESCALE_W, 8, width of cfg_prescale and of the internal prescale counter

Ports:
clk  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin (or restart) counting; config latched on this cycle
stop  input  1  abort; return to IDLE
pause  input  1  level; freezes counting while high in RUN
cfg_limit  input  WIDTH  terminal count value
cfg_prescale  input  PRESCALE_W  q advances once per cfg_prescale+1 active cycles
cfg_reload  input  1  1 = auto-reload at limit, 0 = one-shot
q  output  WIDTH  current count (registered)
busy  output  1  high in RUN or PAUSE
paused  output  1  high in PAUSE
done  output  1  one-cycle pulse when q reaches limit

Behaviour:
- Reset (sync, highest priority): state=IDLE, q=0, prescale counter=0, latched config=0, busy=0, paused=0, done=0.
- States are IDLE, RUN, PAUSE and DONE. Outputs are registered; busy and paused decode the state register.
- Command priority per cycle: reset > stop > start > pause > tick.
- stop, in any state: next state IDLE, q<=0, prescale counter<=0, done<=0.
- start, in any state and without stop: latch cfg_limit, cfg_prescale and cfg_reload. Then q<=0, prescale counter<=0, next state RUN. A start in RUN or PAUSE restarts the count.
- cfg_* are sampled only on an accepted start. Changes at any other time have no effect.
- Tick: in RUN with pause=0, the prescale counter increments each cycle. A tick occurs when the counter equals the latched prescale, and the counter then wraps to 0. With prescale=0, every RUN cycle is a tick.
- On a tick, q<=q+1. If q+1 == latched limit, done<=1 on that same edge.
  - reload=0: next state DONE.
  - reload=1: stay RUN.
- In RUN with reload=1 and q == limit, the next tick sets q<=0, not q+1. Arithmetic never overflows WIDTH.
- limit=0, reload=0: start -> RUN. The first tick sets done=1 and moves to DONE; q stays 0.
- limit=0, reload=1: done pulses on every tick; q stays 0.
- done is high for exactly one cycle per limit hit and is cleared on the next edge unless another hit occurs.
- pause=1 in RUN: next state PAUSE. q and the prescale counter freeze, and no tick occurs in that cycle.
- pause=0 in PAUSE: next state RUN. The prescale counter resumes from its frozen value.
- pause in IDLE or DONE is ignored.
- DONE: q holds the limit, busy=0. Only start or stop leaves DONE.
- IDLE: q=0; pause and ticks have no effect.

Test Plan:
- Reset held for 2 cycles, then released -> q=0, busy=0, paused=0, done=0, state IDLE.
- start=1 for 1 cycle (edge k), limit=3, prescale=0, reload=0 -> q=1,2,3 after edges k+1..k+3. done high only in the cycle after k+3; then busy=0, q holds 3.
- limit=2, prescale=2, reload=1 -> q changes every 3 cycles: 1,2,0,1,2. done pulses when q becomes 2 (edges k+6 and k+15); busy stays 1.
- limit=10, prescale=0, pause high for 4 cycles once q=4 -> paused=1 and q stays 4 for 4 cycles. q resumes 5,6,… after release; done pulses on reaching 10.
- stop and start asserted in the same cycle while q=5 -> stop wins: q=0, state IDLE, busy=0, no done.
- start re-asserted mid-run with q=7 and new limit=2 -> q=0 next cycle with the new config latched; q reaches 2, done pulses, state DONE.
